// File: rtl/stream_packet_arbiter.sv
// Two-port packet-atomic stream arbiter with alternating priority and a small CSR block.
// Each port locks the merged output for a whole packet, and the path through is combinational.
module stream_packet_arbiter #(
    parameter int DATA_BYTES = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DATA_BYTES*8-1:0]       stream_in0_data,
    input  logic [$clog2(DATA_BYTES)-1:0] stream_in0_empty,
    input  logic                          stream_in0_valid,
    input  logic                          stream_in0_startofpacket,
    input  logic                          stream_in0_endofpacket,
    output logic                          stream_in0_ready,
    input  logic [DATA_BYTES*8-1:0]       stream_in1_data,
    input  logic [$clog2(DATA_BYTES)-1:0] stream_in1_empty,
    input  logic                          stream_in1_valid,
    input  logic                          stream_in1_startofpacket,
    input  logic                          stream_in1_endofpacket,
    output logic                          stream_in1_ready,
    output logic [DATA_BYTES*8-1:0]       stream_out_data,
    output logic [$clog2(DATA_BYTES)-1:0] stream_out_empty,
    output logic                          stream_out_valid,
    output logic                          stream_out_startofpacket,
    output logic                          stream_out_endofpacket,
    input  logic                          stream_out_ready,
    input  logic [1:0]                    csr_address,
    input  logic                          csr_read,
    input  logic                          csr_write,
    input  logic [31:0]                   csr_writedata,
    output logic [31:0]                   csr_readdata,
    output logic                          csr_readdatavalid,
    output logic                          csr_waitrequest
);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t      state, state_next;
    logic [1:0]  enable;
    logic        last_grant;
    logic        framing_error;
    logic [31:0] count0, count1;
    logic [31:0] read_mux;
    logic        cand0, cand1, pkt_end, drop;
    logic        unused_wdata;

    assign cand0   = stream_in0_valid & stream_in0_startofpacket & enable[0];
    assign cand1   = stream_in1_valid & stream_in1_startofpacket & enable[1];
    assign pkt_end = stream_out_valid & stream_out_ready & stream_out_endofpacket;
    assign drop    = (state == IDLE) & (stream_in0_ready | stream_in1_ready);
    assign csr_waitrequest = 1'b0;
    assign unused_wdata    = ^csr_writedata[31:3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                // Port 0 wins a tie only when port 1 was the last one granted.
                if (cand0 && (!cand1 || last_grant)) state_next = LOCK0;
                else if (cand1)                      state_next = LOCK1;
            end
            LOCK0, LOCK1: if (pkt_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stream_out_data          = '0;
        stream_out_empty         = '0;
        stream_out_valid         = 1'b0;
        stream_out_startofpacket = 1'b0;
        stream_out_endofpacket   = 1'b0;
        stream_in0_ready         = 1'b0;
        stream_in1_ready         = 1'b0;
        unique case (state)
            IDLE: begin
                // Mid-packet beats seen while unlocked are swallowed; reset gates this off.
                stream_in0_ready = reset_n & enable[0] & stream_in0_valid & ~stream_in0_startofpacket;
                stream_in1_ready = reset_n & enable[1] & stream_in1_valid & ~stream_in1_startofpacket;
            end
            LOCK0: begin
                stream_out_data          = stream_in0_data;
                stream_out_empty         = stream_in0_empty;
                stream_out_valid         = stream_in0_valid;
                stream_out_startofpacket = stream_in0_startofpacket;
                stream_out_endofpacket   = stream_in0_endofpacket;
                stream_in0_ready         = stream_out_ready;
            end
            LOCK1: begin
                stream_out_data          = stream_in1_data;
                stream_out_empty         = stream_in1_empty;
                stream_out_valid         = stream_in1_valid;
                stream_out_startofpacket = stream_in1_startofpacket;
                stream_out_endofpacket   = stream_in1_endofpacket;
                stream_in1_ready         = stream_out_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable        <= 2'b11;
            last_grant    <= 1'b1;
            framing_error <= 1'b0;
            count0        <= '0;
            count1        <= '0;
        end else begin
            if (pkt_end) last_grant <= (state == LOCK1);
            if (csr_write && csr_address == 2'd0) enable <= csr_writedata[1:0];
            if (drop)
                framing_error <= 1'b1;
            else if (csr_write && csr_address == 2'd1 && csr_writedata[2])
                framing_error <= 1'b0;
            if (csr_write && csr_address == 2'd2)  count0 <= '0;
            else if (pkt_end && state == LOCK0)    count0 <= count0 + 32'd1;
            if (csr_write && csr_address == 2'd3)  count1 <= '0;
            else if (pkt_end && state == LOCK1)    count1 <= count1 + 32'd1;
        end
    end

    always_comb begin
        read_mux = '0;
        unique case (csr_address)
            2'd0: read_mux = {30'b0, enable};
            2'd1: read_mux = {29'b0, framing_error, state == LOCK1, state != IDLE};
            2'd2: read_mux = count0;
            2'd3: read_mux = count1;
            default: read_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csr_readdata      <= '0;
            csr_readdatavalid <= 1'b0;
        end else begin
            csr_readdatavalid <= csr_read & ~csr_write;
            if (csr_read && !csr_write) csr_readdata <= read_mux;
        end
    end

endmodule

// File: doc/stream_packet_arbiter.md
STREAM_PACKET_ARBITER -- requirements
Module: stream_packet_arbiter

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 8, meaning bytes per stream beat (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have, for k in {0,1}, stream_ink_data  input  DATA_BYTES*8  requester k beat data.
REQ-005 SHALL have stream_ink_empty  input  $clog2(DATA_BYTES); stream_ink_valid, stream_ink_startofpacket, stream_ink_endofpacket  input  1 each; stream_ink_ready  output  1.
REQ-006 SHALL have stream_out_data  output  DATA_BYTES*8; stream_out_empty  output  $clog2(DATA_BYTES); stream_out_valid, stream_out_startofpacket, stream_out_endofpacket  output  1 each; stream_out_ready  input  1: merged stream toward the swapper.
REQ-007 SHALL have csr_address  input  2; csr_read, csr_write  input  1; csr_writedata  input  32; csr_readdata  output  32; csr_readdatavalid  output  1; csr_waitrequest  output  1.

Function
REQ-008 SHALL implement states IDLE, LOCK0, LOCK1; reset state IDLE.
REQ-009 SHALL treat port k as a candidate in IDLE when stream_ink_valid=1, stream_ink_startofpacket=1 and enable bit k=1.
REQ-010 SHALL, in IDLE with one candidate, move to LOCKk next cycle; with two candidates, grant the port not granted last (last_grant resets to 1, so port 0 wins first).
REQ-011 SHALL, in IDLE, drive stream_out_valid=0 and both stream_ink_ready=0, except as in REQ-016.
REQ-012 SHALL, in LOCKk, connect port k to the output combinationally: stream_out_* = stream_ink_*, stream_ink_ready = stream_out_ready, other port ready=0; zero added latency.
REQ-013 SHALL count a beat transfer when stream_out_valid=1 and stream_out_ready=1.
REQ-014 SHALL, on a transfer with endofpacket=1 in LOCKk, set last_grant=k, increment packet counter k (32-bit, wrap 0xFFFFFFFF->0) and return to IDLE; one idle cycle between packets minimum.
REQ-015 SHALL complete a locked packet even if enable bit k is cleared mid-packet; the clear takes effect at the next arbitration.
REQ-016 SHALL, in IDLE, assert stream_ink_ready=1 for an enabled port presenting valid=1 with startofpacket=0, discard that beat and set sticky framing_error.
REQ-017 SHALL handle a single-beat packet (sop=eop=1) as a complete packet: one LOCK cycle if accepted.
REQ-018 SHALL map CSR address 0 = control (bit0 enable0, bit1 enable1, RW, reset 2'b11).
REQ-019 SHALL map address 1 = status (bit0 busy = not IDLE, bit1 locked port, bit2 framing_error; writing 1 to bit2 clears it; other bits read 0).
REQ-020 SHALL map addresses 2/3 = packet counter 0/1, read-only; any write clears to 0; a write coinciding with an increment yields 0.
REQ-021 SHALL return csr_readdata with csr_readdatavalid=1 exactly one cycle after csr_read; csr_readdata holds otherwise; csr_waitrequest=0 always.
REQ-022 SHALL give csr_write precedence when csr_read and csr_write are both asserted; no read response issued.
REQ-023 SHALL set framing_error on the same cycle as a new error when the W1C clear coincides (set wins).

Reset
REQ-024 SHALL, while reset_n=0, force state IDLE, last_grant=1, enables=2'b11, counters=0, framing_error=0, csr_readdata=0, csr_readdatavalid=0, stream_out_valid=0, both readies=0.
REQ-025 SHALL abandon any in-flight packet on reset assertion; no partial-packet recovery after release.

Verification
REQ-026 Both ports present 3-beat packets continuously, out_ready=1 -> output order P0,P1,P0,P1; counters 2/3 track equal counts.
REQ-027 Port 0 only, out_ready toggled 1010 -> every beat delivered once, data unchanged, ready0 mirrors out_ready in LOCK0.
REQ-028 Write control=0x1, port 1 valid sop -> ready1 stays 0, port 1 never granted; write 0x3 -> port 1 granted next IDLE.
REQ-029 Port 0 valid with sop=0 in IDLE -> beat consumed, status bit2=1; write status 0x4 -> bit2 reads 0.
REQ-030 Assert reset_n=0 mid-packet in LOCK1 -> outputs and readies 0 immediately; after release status reads 0, counters read 0, control reads 0x3.
